// File: rtl/sprite_bounce.sv
// Bouncing-sprite renderer: 2-stage pixel pipe feeding a synchronous sprite ROM, plus per-frame motion.
// Optional SPRITE_KEY_EN: rom_data equal to KEY is treated as transparent and shows the background colour.
module sprite_bounce #(
    parameter int H_ACTIVE = 1600,
    parameter int V_ACTIVE = 1200,
    parameter int SPR_W    = 128,
    parameter int SPR_H    = 128,
    parameter int STEP     = 1,
    parameter int X0       = 2,
    parameter int Y0       = 2,
    parameter int AW       = 16
`ifdef SPRITE_KEY_EN
    ,
    parameter logic [7:0] KEY = 8'hFF
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ACTIVE,
    input  logic          VSYNC,
    input  logic [12:0]   h,
    input  logic [12:0]   v,
    input  logic [7:0]    colour,
    input  logic          pause,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [7:0]    rgb,
    output logic          hit_x,
    output logic          hit_y,
    output logic [15:0]   bounce_cnt
);

    localparam logic [13:0] C_SW   = 14'(SPR_W);
    localparam logic [13:0] C_SH   = 14'(SPR_H);
    localparam logic [13:0] C_STEP = 14'(STEP);
    localparam logic [13:0] C_H    = 14'(H_ACTIVE);
    localparam logic [13:0] C_V    = 14'(V_ACTIVE);
    localparam logic [13:0] C_XMAX = 14'(H_ACTIVE - SPR_W);
    localparam logic [13:0] C_YMAX = 14'(V_ACTIVE - SPR_H);

    logic [13:0]   r_o_x, r_o_y;
    logic          r_d_x, r_d_y;
    logic          r_vs_q;
    logic          r_in_win_d1, r_in_win_d2;
    logic          r_act_d1, r_act_d2;

    logic [13:0]   w_h, w_v, w_off_x, w_off_y;
    logic          w_in_win, w_tick;
    logic          w_hit_r, w_hit_l, w_hit_b, w_hit_t;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_sprite_px;

    assign w_h     = {1'b0, h};
    assign w_v     = {1'b0, v};
    assign w_off_x = w_h - r_o_x;
    assign w_off_y = w_v - r_o_y;
    assign w_in_win = (w_h >= r_o_x) && (w_h < r_o_x + C_SW) &&
                      (w_v >= r_o_y) && (w_v < r_o_y + C_SH);
    assign w_addr  = AW'(w_off_y) * AW'(SPR_W) + AW'(w_off_x);

    // A frame starts one cycle after VSYNC falls; the origin only moves here.
    assign w_tick  = r_vs_q & ~VSYNC;

    assign w_hit_r = r_d_x  && (r_o_x + C_SW + C_STEP >= C_H);
    assign w_hit_l = !r_d_x && (r_o_x <= C_STEP);
    assign w_hit_b = r_d_y  && (r_o_y + C_SH + C_STEP >= C_V);
    assign w_hit_t = !r_d_y && (r_o_y <= C_STEP);

`ifdef SPRITE_KEY_EN
    assign w_sprite_px = (rom_data == KEY) ? colour : rom_data;
`else
    assign w_sprite_px = rom_data;
`endif

    // NOTE: all state here uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rom_addr    <= '0;
            rgb         <= 8'h00;
            hit_x       <= 1'b0;
            hit_y       <= 1'b0;
            bounce_cnt  <= 16'd0;
            r_o_x       <= 14'(X0);
            r_o_y       <= 14'(Y0);
            r_d_x       <= 1'b1;
            r_d_y       <= 1'b1;
            r_vs_q      <= 1'b0;
            r_in_win_d1 <= 1'b0;
            r_in_win_d2 <= 1'b0;
            r_act_d1    <= 1'b0;
            r_act_d2    <= 1'b0;
        end else begin
            r_vs_q      <= VSYNC;
            r_in_win_d1 <= w_in_win;
            r_in_win_d2 <= r_in_win_d1;
            r_act_d1    <= ACTIVE;
            r_act_d2    <= r_act_d1;
            if (w_in_win)
                rom_addr <= w_addr;
            rgb <= !r_act_d2 ? 8'h00 : (r_in_win_d2 ? w_sprite_px : colour);

            hit_x <= 1'b0;
            hit_y <= 1'b0;
            if (w_tick && !pause) begin
                if (w_hit_r) begin
                    r_o_x <= C_XMAX;
                    r_d_x <= 1'b0;
                    hit_x <= 1'b1;
                end else if (w_hit_l) begin
                    r_o_x <= 14'd0;
                    r_d_x <= 1'b1;
                    hit_x <= 1'b1;
                end else begin
                    r_o_x <= r_d_x ? r_o_x + C_STEP : r_o_x - C_STEP;
                end

                if (w_hit_b) begin
                    r_o_y <= C_YMAX;
                    r_d_y <= 1'b0;
                    hit_y <= 1'b1;
                end else if (w_hit_t) begin
                    r_o_y <= 14'd0;
                    r_d_y <= 1'b1;
                    hit_y <= 1'b1;
                end else begin
                    r_o_y <= r_d_y ? r_o_y + C_STEP : r_o_y - C_STEP;
                end

                // A corner hit counts as one bounce.
                if (w_hit_r || w_hit_l || w_hit_b || w_hit_t)
                    bounce_cnt <= bounce_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_bounce.sv
// Directed bench for sprite_bounce: reset, pixel fetch, edge bounces, corner, pause and colour key.
// Three instances share stimulus: defaults, STEP=3, and X0=402 (reaches the corner in step).
module tb_sprite_bounce;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ACTIVE = 1'b0;
    logic        VSYNC = 1'b0;
    logic        pause = 1'b0;
    logic        no_pause = 1'b0;
    logic [12:0] h = '0;
    logic [12:0] v = '0;
    logic [7:0]  colour = 8'hE0;
    logic [7:0]  rom_data = 8'h00;

    logic [15:0] rom_addr, rom_addr_s3, rom_addr_c;
    logic [7:0]  rgb, rgb_s3, rgb_c;
    logic        hit_x, hit_y, hit_x_s3, hit_y_s3, hit_x_c, hit_y_c;
    logic [15:0] bounce_cnt, bounce_cnt_s3, bounce_cnt_c;

    int err_cnt = 0;
    int chk_cnt = 0;
    int n_frames = 0;

    always #5 CLK = ~CLK;

    sprite_bounce dut (
        .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .VSYNC(VSYNC), .h(h), .v(v),
        .colour(colour), .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .hit_x(hit_x), .hit_y(hit_y), .bounce_cnt(bounce_cnt)
    );

    sprite_bounce #(.STEP(3)) u_s3 (
        .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .VSYNC(VSYNC), .h(h), .v(v),
        .colour(colour), .pause(no_pause), .rom_addr(rom_addr_s3), .rom_data(rom_data),
        .rgb(rgb_s3), .hit_x(hit_x_s3), .hit_y(hit_y_s3), .bounce_cnt(bounce_cnt_s3)
    );

    sprite_bounce #(.X0(402)) u_c (
        .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .VSYNC(VSYNC), .h(h), .v(v),
        .colour(colour), .pause(no_pause), .rom_addr(rom_addr_c), .rom_data(rom_data),
        .rgb(rgb_c), .hit_x(hit_x_c), .hit_y(hit_y_c), .bounce_cnt(bounce_cnt_c)
    );

    // Synchronous ROM model: address 258 holds 8'h1C, elsewhere the low address byte.
    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        if (a == 16'd258)
            return 8'h1C;
        return a[7:0];
    endfunction

    always @(posedge CLK) rom_data <= rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clk();
        @(posedge CLK);
        #1;
    endtask

    // One frame: VSYNC high for a cycle, then low; the second edge is the tick edge.
    task automatic frame();
        VSYNC = 1'b1;
        clk();
        VSYNC = 1'b0;
        clk();
        n_frames++;
    endtask

    task automatic run_to(input int target);
        while (n_frames < target)
            frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with active video already present; outputs must stay cleared.
        ACTIVE = 1'b1;
        h = 13'd0;
        v = 13'd0;
        repeat (4) clk();
        check("rst_rgb", rgb, 8'h00);
        check("rst_rom_addr", rom_addr, 16'd0);
        check("rst_bounce", bounce_cnt, 16'd0);
        check("rst_hit_x", hit_x, 1'b0);
        check("rst_o_x", dut.r_o_x, 2);
        check("rst_o_y", dut.r_o_y, 2);
        check("rst_d_x", dut.r_d_x, 1'b1);
        check("rst_d_y", dut.r_d_y, 1'b1);

        // Pipe refill: two zero cycles after release, then background.
        RST = 1'b0;
        clk();
        check("refill_rgb_1", rgb, 8'h00);
        clk();
        check("refill_rgb_2", rgb, 8'h00);
        clk();
        check("refill_rgb_3", rgb, 8'hE0);

        // Pixel fetch: (4,4) -> (4-2)*128 + (4-2) = 258.
        h = 13'd4;
        v = 13'd4;
        clk();
        check("fetch_addr", rom_addr, 16'd258);
        h = 13'd130;
        clk();
        check("fetch_addr_held", rom_addr, 16'd258);
        ACTIVE = 1'b0;
        clk();
        check("fetch_rgb_sprite", rgb, 8'h1C);
        clk();
        check("fetch_rgb_outside", rgb, 8'hE0);
        clk();
        check("fetch_rgb_blank", rgb, 8'h00);

        // Colour key: (129,3) -> 1*128 + 127 = 255, ROM returns 8'hFF.
        ACTIVE = 1'b1;
        colour = 8'h03;
        h = 13'd129;
        v = 13'd3;
        clk();
        check("key_addr", rom_addr, 16'd255);
        clk();
        clk();
`ifdef SPRITE_KEY_EN
        check("key_rgb", rgb, 8'h03);
`else
        check("key_rgb", rgb, 8'hFF);
`endif
        ACTIVE = 1'b0;

        // STEP=3 right bounce: after 489 ticks o_x = 2 + 3*489 = 1469 (y bounced once at tick 357).
        run_to(489);
        check("s3_o_x_pre", u_s3.r_o_x, 1469);
        check("s3_bounce_pre", bounce_cnt_s3, 1);
        frame();
        check("s3_o_x_hit", u_s3.r_o_x, 1472);
        check("s3_d_x_hit", u_s3.r_d_x, 1'b0);
        check("s3_hit_x", hit_x_s3, 1'b1);
        check("s3_hit_y_quiet", hit_y_s3, 1'b0);
        check("s3_bounce_hit", bounce_cnt_s3, 2);
        clk();
        check("s3_hit_x_pulse", hit_x_s3, 1'b0);
        frame();
        check("s3_o_x_back", u_s3.r_o_x, 1469);
        check("s3_hit_x_next", hit_x_s3, 1'b0);

        // STEP=3 top bounce: o_y = 1072 - 3*(714-357) = 1 then clamps to 0.
        run_to(714);
        check("s3_o_y_pre", u_s3.r_o_y, 1);
        frame();
        check("s3_o_y_top", u_s3.r_o_y, 0);
        check("s3_d_y_top", u_s3.r_d_y, 1'b1);
        check("s3_hit_y_top", hit_y_s3, 1'b1);
        check("s3_bounce_top", bounce_cnt_s3, 3);

        // Corner on the X0=402 instance at tick 1070; default instance bounces on y only.
        run_to(1069);
        check("c_o_x_pre", u_c.r_o_x, 1471);
        check("c_o_y_pre", u_c.r_o_y, 1071);
        check("c_bounce_pre", bounce_cnt_c, 0);
        frame();
        check("c_o_x", u_c.r_o_x, 1472);
        check("c_o_y", u_c.r_o_y, 1072);
        check("c_d_x", u_c.r_d_x, 1'b0);
        check("c_d_y", u_c.r_d_y, 1'b0);
        check("c_hit_x", hit_x_c, 1'b1);
        check("c_hit_y", hit_y_c, 1'b1);
        check("c_bounce", bounce_cnt_c, 1);
        check("main_o_x", dut.r_o_x, 1072);
        check("main_o_y", dut.r_o_y, 1072);
        check("main_hit_y", hit_y, 1'b1);
        check("main_bounce", bounce_cnt, 1);

        // Pause across three frame ticks, then release.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame();
            check("pause_hit_x", hit_x, 1'b0);
            check("pause_hit_y", hit_y, 1'b0);
        end
        check("pause_o_x", dut.r_o_x, 1072);
        check("pause_o_y", dut.r_o_y, 1072);
        check("pause_d_x", dut.r_d_x, 1'b1);
        check("pause_d_y", dut.r_d_y, 1'b0);
        check("pause_bounce", bounce_cnt, 1);
        pause = 1'b0;
        frame();
        check("resume_o_x", dut.r_o_x, 1073);
        check("resume_o_y", dut.r_o_y, 1071);
        check("resume_hit_y", hit_y, 1'b0);
        check("resume_bounce", bounce_cnt, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
